// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared types and constants for the MEM-stage data-memory port
package dmem_pkg;

  typedef enum logic [2:0] {
    LD_NONE = 3'd0,
    LD_W    = 3'd1,
    LD_H    = 3'd2,
    LD_B    = 3'd3,
    LD_HU   = 3'd4,
    LD_BU   = 3'd5
  } load_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  localparam logic [3:0] BWEB_NONE = 4'b1111;

  // Encodings 110/111 are reserved and behave as "no load".
  function automatic load_e decode_load(input logic [2:0] code);
    case (code)
      3'd1:    decode_load = LD_W;
      3'd2:    decode_load = LD_H;
      3'd3:    decode_load = LD_B;
      3'd4:    decode_load = LD_HU;
      3'd5:    decode_load = LD_BU;
      default: decode_load = LD_NONE;
    endcase
  endfunction

endpackage

// File: rtl/load_align.sv
// rtl/load_align.sv - combinational lane selection and sign/zero extension of a read word
module load_align
  import dmem_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [2:0]  load_type_i,
  output logic [31:0] result_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  load_e       ld_type;

  assign ld_type = decode_load(load_type_i);

  always_comb begin
    byte_sel = rdata_i[7:0];
    case (addr_lo_i)
      2'd0: byte_sel = rdata_i[7:0];
      2'd1: byte_sel = rdata_i[15:8];
      2'd2: byte_sel = rdata_i[23:16];
      2'd3: byte_sel = rdata_i[31:24];
      default: byte_sel = rdata_i[7:0];
    endcase
  end

  assign half_sel = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];

  always_comb begin
    result_o = '0;
    case (ld_type)
      LD_W:    result_o = rdata_i;
      LD_H:    result_o = {{16{half_sel[15]}}, half_sel};
      LD_HU:   result_o = {16'h0000, half_sel};
      LD_B:    result_o = {{24{byte_sel[7]}}, byte_sel};
      LD_BU:   result_o = {24'h000000, byte_sel};
      default: result_o = '0;
    endcase
  end

endmodule

// File: rtl/dmem_bus_port.sv
// rtl/dmem_bus_port.sv - runs one EX/MEM load/store as a valid/ready bus transaction, stalling the pipe
module dmem_bus_port
  import dmem_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [3:0]        mem_bweb,
  input  logic [DATA_W-1:0] mem_wdata,
  input  logic [2:0]        is_load,
  output logic              stall,
  output logic              bus_req_valid,
  input  logic              bus_req_ready,
  output logic [ADDR_W-1:0] bus_req_addr,
  output logic              bus_req_write,
  output logic [3:0]        bus_req_wstrb,
  output logic [DATA_W-1:0] bus_req_wdata,
  input  logic              bus_rsp_valid,
  input  logic [DATA_W-1:0] bus_rsp_rdata,
  input  logic              bus_rsp_err,
  output logic [DATA_W-1:0] load_data,
  output logic              load_valid,
  output logic              access_err
);

  state_e            state_q, state_d;
  logic              load_valid_q, load_valid_d;
  logic              access_err_q, access_err_d;
  logic [DATA_W-1:0] load_data_q, load_data_d;

  logic              is_store;
  logic              is_ld;
  logic              pending;
  logic              misaligned;
  logic              stall_c;
  load_e             ld_type;
  logic [DATA_W-1:0] aligned;

  // A store takes priority; a simultaneous load request is dropped.
  assign is_store   = (mem_bweb != BWEB_NONE);
  assign ld_type    = decode_load(is_load);
  assign is_ld      = !is_store && (ld_type != LD_NONE);
  assign pending    = is_store || is_ld;
  assign misaligned = is_ld &&
                      (((ld_type == LD_W) && (mem_addr[1:0] != 2'b00)) ||
                       (((ld_type == LD_H) || (ld_type == LD_HU)) && (mem_addr[1:0] == 2'b11)));

  load_align u_load_align (
    .rdata_i     (bus_rsp_rdata),
    .addr_lo_i   (mem_addr[1:0]),
    .load_type_i (is_load),
    .result_o    (aligned)
  );

  assign bus_req_addr  = {mem_addr[ADDR_W-1:2], 2'b00};
  assign bus_req_write = is_store;
  assign bus_req_wstrb = is_store ? ~mem_bweb : 4'b0000;
  assign bus_req_wdata = mem_wdata;

  always_comb begin
    state_d       = state_q;
    load_valid_d  = 1'b0;
    access_err_d  = 1'b0;
    load_data_d   = '0;
    bus_req_valid = 1'b0;
    stall_c       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pending) begin
          stall_c = 1'b1;
          if (misaligned) begin
            state_d      = ST_DONE;
            access_err_d = 1'b1;
          end else begin
            state_d = ST_REQ;
          end
        end
      end
      ST_REQ: begin
        stall_c       = 1'b1;
        bus_req_valid = 1'b1;
        if (bus_req_ready) begin
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        stall_c = 1'b1;
        if (bus_rsp_valid) begin
          state_d = ST_DONE;
          if (bus_rsp_err) begin
            access_err_d = 1'b1;
          end else if (is_ld) begin
            load_valid_d = 1'b1;
            load_data_d  = aligned;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      load_valid_q <= 1'b0;
      access_err_q <= 1'b0;
      load_data_q  <= '0;
    end else begin
      state_q      <= state_d;
      load_valid_q <= load_valid_d;
      access_err_q <= access_err_d;
      load_data_q  <= load_data_d;
    end
  end

  assign stall      = stall_c && !rst;
  assign load_valid = load_valid_q;
  assign access_err = access_err_q;
  assign load_data  = load_data_q;

endmodule

// File: tb/tb_dmem_bus_port.sv
// tb/tb_dmem_bus_port.sv - directed self-checking bench for dmem_bus_port
module tb_dmem_bus_port;

  logic        clk;
  logic        rst;
  logic [31:0] mem_addr;
  logic [3:0]  mem_bweb;
  logic [31:0] mem_wdata;
  logic [2:0]  is_load;
  logic        stall;
  logic        bus_req_valid;
  logic        bus_req_ready;
  logic [31:0] bus_req_addr;
  logic        bus_req_write;
  logic [3:0]  bus_req_wstrb;
  logic [31:0] bus_req_wdata;
  logic        bus_rsp_valid;
  logic [31:0] bus_rsp_rdata;
  logic        bus_rsp_err;
  logic [31:0] load_data;
  logic        load_valid;
  logic        access_err;

  int checks;
  int errors;
  int hs_count;
  int hs_base;

  dmem_bus_port #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk           (clk),
    .rst           (rst),
    .mem_addr      (mem_addr),
    .mem_bweb      (mem_bweb),
    .mem_wdata     (mem_wdata),
    .is_load       (is_load),
    .stall         (stall),
    .bus_req_valid (bus_req_valid),
    .bus_req_ready (bus_req_ready),
    .bus_req_addr  (bus_req_addr),
    .bus_req_write (bus_req_write),
    .bus_req_wstrb (bus_req_wstrb),
    .bus_req_wdata (bus_req_wdata),
    .bus_rsp_valid (bus_rsp_valid),
    .bus_rsp_rdata (bus_rsp_rdata),
    .bus_rsp_err   (bus_rsp_err),
    .load_data     (load_data),
    .load_valid    (load_valid),
    .access_err    (access_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!rst && bus_req_valid && bus_req_ready) hs_count <= hs_count + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are checked at the falling edge.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    mem_addr      = 32'h0;
    mem_bweb      = 4'b1111;
    mem_wdata     = 32'h0;
    is_load       = 3'd0;
    bus_req_ready = 1'b0;
    bus_rsp_valid = 1'b0;
    bus_rsp_rdata = 32'h0;
    bus_rsp_err   = 1'b0;
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    hs_count = 0;
    rst      = 1'b1;
    idle_inputs();
    next_cycle();
    next_cycle();
    sample();
    chk("rst_stall", {31'b0, stall}, 32'h0);
    next_cycle();
    rst = 1'b0;
    sample();
    chk("rst_req_valid", {31'b0, bus_req_valid}, 32'h0);
    chk("rst_load_valid", {31'b0, load_valid}, 32'h0);
    chk("rst_access_err", {31'b0, access_err}, 32'h0);
    chk("rst_load_data", load_data, 32'h0);

    // LB 0x1003, immediate ready and response
    next_cycle();
    mem_addr = 32'h0000_1003; is_load = 3'd3; bus_req_ready = 1'b1;
    sample();
    chk("lb_c0_stall", {31'b0, stall}, 32'h1);
    chk("lb_c0_valid", {31'b0, bus_req_valid}, 32'h0);
    next_cycle();
    sample();
    chk("lb_c1_valid", {31'b0, bus_req_valid}, 32'h1);
    chk("lb_c1_stall", {31'b0, stall}, 32'h1);
    chk("lb_c1_addr", bus_req_addr, 32'h0000_1000);
    chk("lb_c1_write", {31'b0, bus_req_write}, 32'h0);
    chk("lb_c1_wstrb", {28'b0, bus_req_wstrb}, 32'h0);
    next_cycle();
    bus_req_ready = 1'b0; bus_rsp_valid = 1'b1; bus_rsp_rdata = 32'h80FF_1234;
    sample();
    chk("lb_c2_stall", {31'b0, stall}, 32'h1);
    chk("lb_c2_valid", {31'b0, bus_req_valid}, 32'h0);
    next_cycle();
    bus_rsp_valid = 1'b0;
    sample();
    chk("lb_c3_stall", {31'b0, stall}, 32'h0);
    chk("lb_c3_load_valid", {31'b0, load_valid}, 32'h1);
    chk("lb_c3_load_data", load_data, 32'hFFFF_FF80);
    chk("lb_c3_access_err", {31'b0, access_err}, 32'h0);
    next_cycle();
    idle_inputs();
    sample();
    chk("lb_c4_load_valid", {31'b0, load_valid}, 32'h0);
    chk("lb_c4_stall", {31'b0, stall}, 32'h0);

    // LHU 0x2002, ready withheld for 4 request cycles
    next_cycle();
    mem_addr = 32'h0000_2002; is_load = 3'd4;
    sample();
    chk("lhu_c0_stall", {31'b0, stall}, 32'h1);
    for (int i = 0; i < 4; i++) begin
      next_cycle();
      sample();
      chk("lhu_wait_valid", {31'b0, bus_req_valid}, 32'h1);
      chk("lhu_wait_addr", bus_req_addr, 32'h0000_2000);
    end
    next_cycle();
    bus_req_ready = 1'b1;
    sample();
    chk("lhu_acc_valid", {31'b0, bus_req_valid}, 32'h1);
    chk("lhu_acc_addr", bus_req_addr, 32'h0000_2000);
    next_cycle();
    bus_req_ready = 1'b0; bus_rsp_valid = 1'b1; bus_rsp_rdata = 32'hBEEF_0000;
    sample();
    chk("lhu_resp_valid", {31'b0, bus_req_valid}, 32'h0);
    next_cycle();
    bus_rsp_valid = 1'b0;
    sample();
    chk("lhu_done_load_valid", {31'b0, load_valid}, 32'h1);
    chk("lhu_done_load_data", load_data, 32'h0000_BEEF);
    next_cycle();
    idle_inputs();

    // SB, bweb=1101
    next_cycle();
    mem_addr = 32'h0000_4001; mem_bweb = 4'b1101; mem_wdata = 32'h0000_AB00; bus_req_ready = 1'b1;
    sample();
    chk("sb_c0_stall", {31'b0, stall}, 32'h1);
    next_cycle();
    sample();
    chk("sb_c1_valid", {31'b0, bus_req_valid}, 32'h1);
    chk("sb_c1_write", {31'b0, bus_req_write}, 32'h1);
    chk("sb_c1_wstrb", {28'b0, bus_req_wstrb}, 32'h0000_0002);
    chk("sb_c1_wdata", bus_req_wdata, 32'h0000_AB00);
    chk("sb_c1_addr", bus_req_addr, 32'h0000_4000);
    next_cycle();
    bus_req_ready = 1'b0; bus_rsp_valid = 1'b1; bus_rsp_rdata = 32'hDEAD_BEEF;
    sample();
    next_cycle();
    bus_rsp_valid = 1'b0;
    sample();
    chk("sb_done_stall", {31'b0, stall}, 32'h0);
    chk("sb_done_load_valid", {31'b0, load_valid}, 32'h0);
    chk("sb_done_access_err", {31'b0, access_err}, 32'h0);
    chk("sb_done_load_data", load_data, 32'h0);
    next_cycle();
    idle_inputs();

    // Misaligned LW 0x3001
    hs_base = hs_count;
    next_cycle();
    mem_addr = 32'h0000_3001; is_load = 3'd1; bus_req_ready = 1'b1;
    sample();
    chk("mis_c0_stall", {31'b0, stall}, 32'h1);
    chk("mis_c0_valid", {31'b0, bus_req_valid}, 32'h0);
    next_cycle();
    sample();
    chk("mis_c1_valid", {31'b0, bus_req_valid}, 32'h0);
    chk("mis_c1_access_err", {31'b0, access_err}, 32'h1);
    chk("mis_c1_load_valid", {31'b0, load_valid}, 32'h0);
    chk("mis_c1_load_data", load_data, 32'h0);
    chk("mis_c1_stall", {31'b0, stall}, 32'h0);
    next_cycle();
    idle_inputs();
    sample();
    chk("mis_c2_access_err", {31'b0, access_err}, 32'h0);
    chk("mis_no_handshake", hs_count - hs_base, 32'h0);

    // LW with bus error
    next_cycle();
    mem_addr = 32'h0000_5000; is_load = 3'd1; bus_req_ready = 1'b1;
    sample();
    next_cycle();
    sample();
    chk("err_c1_valid", {31'b0, bus_req_valid}, 32'h1);
    next_cycle();
    bus_req_ready = 1'b0; bus_rsp_valid = 1'b1; bus_rsp_err = 1'b1; bus_rsp_rdata = 32'h1234_5678;
    sample();
    next_cycle();
    bus_rsp_valid = 1'b0; bus_rsp_err = 1'b0;
    sample();
    chk("err_done_access_err", {31'b0, access_err}, 32'h1);
    chk("err_done_load_valid", {31'b0, load_valid}, 32'h0);
    chk("err_done_load_data", load_data, 32'h0);
    next_cycle();
    idle_inputs();
    sample();
    chk("err_after_access_err", {31'b0, access_err}, 32'h0);

    // Reset during RESP, then a late response in IDLE
    next_cycle();
    mem_addr = 32'h0000_6000; is_load = 3'd1; bus_req_ready = 1'b1;
    sample();
    next_cycle();
    sample();
    next_cycle();
    bus_req_ready = 1'b0;
    sample();
    chk("rr_resp_stall", {31'b0, stall}, 32'h1);
    rst = 1'b1;
    #1;
    chk("rr_rst_stall", {31'b0, stall}, 32'h0);
    next_cycle();
    rst = 1'b0;
    idle_inputs();
    bus_rsp_valid = 1'b1; bus_rsp_rdata = 32'hFFFF_FFFF;
    sample();
    chk("rr_idle_stall", {31'b0, stall}, 32'h0);
    chk("rr_idle_valid", {31'b0, bus_req_valid}, 32'h0);
    chk("rr_idle_load_valid", {31'b0, load_valid}, 32'h0);
    chk("rr_idle_access_err", {31'b0, access_err}, 32'h0);
    chk("rr_idle_load_data", load_data, 32'h0);
    next_cycle();
    bus_rsp_valid = 1'b0;
    sample();
    chk("rr_late_load_valid", {31'b0, load_valid}, 32'h0);
    chk("rr_late_load_data", load_data, 32'h0);

    // Back-to-back LW then SW
    hs_base = hs_count;
    next_cycle();
    mem_addr = 32'h0000_7004; is_load = 3'd1; bus_req_ready = 1'b1;
    sample();
    next_cycle();
    sample();
    chk("b2b_lw_addr", bus_req_addr, 32'h0000_7004);
    next_cycle();
    bus_req_ready = 1'b0; bus_rsp_valid = 1'b1; bus_rsp_rdata = 32'hCAFE_BABE;
    sample();
    chk("b2b_lw_resp_stall", {31'b0, stall}, 32'h1);
    next_cycle();
    bus_rsp_valid = 1'b0;
    sample();
    chk("b2b_lw_done_stall", {31'b0, stall}, 32'h0);
    chk("b2b_lw_load_data", load_data, 32'hCAFE_BABE);
    chk("b2b_lw_load_valid", {31'b0, load_valid}, 32'h1);
    next_cycle();
    is_load = 3'd0; mem_addr = 32'h0000_7008; mem_bweb = 4'b0000; mem_wdata = 32'h1122_3344;
    bus_req_ready = 1'b1;
    sample();
    chk("b2b_sw_c0_stall", {31'b0, stall}, 32'h1);
    chk("b2b_sw_c0_load_valid", {31'b0, load_valid}, 32'h0);
    next_cycle();
    sample();
    chk("b2b_sw_write", {31'b0, bus_req_write}, 32'h1);
    chk("b2b_sw_wstrb", {28'b0, bus_req_wstrb}, 32'h0000_000F);
    chk("b2b_sw_addr", bus_req_addr, 32'h0000_7008);
    next_cycle();
    bus_req_ready = 1'b0; bus_rsp_valid = 1'b1; bus_rsp_rdata = 32'h0;
    sample();
    next_cycle();
    bus_rsp_valid = 1'b0;
    sample();
    chk("b2b_sw_done_stall", {31'b0, stall}, 32'h0);
    chk("b2b_sw_done_load_valid", {31'b0, load_valid}, 32'h0);
    next_cycle();
    idle_inputs();
    sample();
    chk("b2b_handshakes", hs_count - hs_base, 32'h2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_bus_port.md
# dmem_bus_port

MEM-stage data-memory port: takes the load/store access presented by the EX/MEM pipeline register and runs it as a single valid/ready transaction on the data bus. It holds the pipeline via `stall` until the transaction completes. For loads, it returns the addressed byte, halfword or word, sign- or zero-extended. It is the responder/reader end of the store-data and byte-write-enable path generated in EX.

## Interface
Parameters:
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width; only 32 is supported

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge
- `rst`  in  1  synchronous, active-high reset
- `mem_addr`  in  32  byte address of the access (ALU result in MEM)
- `mem_bweb`  in  4  byte write enables, active-low; `4'b1111` = no store
- `mem_wdata`  in  32  store data, already byte-lane aligned
- `is_load`  in  3  load type: 000 none, 001 LW, 010 LH, 011 LB, 100 LHU, 101 LBU; 110/111 treated as none
- `stall`  out  1  hold the EX/MEM and earlier stages (drives `busStall[1]`)
- `bus_req_valid`  out  1  request valid
- `bus_req_ready`  in  1  request accepted
- `bus_req_addr`  out  32  `{mem_addr[31:2],2'b00}`
- `bus_req_write`  out  1  1 = store
- `bus_req_wstrb`  out  4  active-high byte strobes = `~mem_bweb`; 0 for loads
- `bus_req_wdata`  out  32  `mem_wdata`
- `bus_rsp_valid`  in  1  response valid; one cycle per request
- `bus_rsp_rdata`  in  32  read word
- `bus_rsp_err`  in  1  error, qualified by `bus_rsp_valid`
- `load_data`  out  32  extended load result; valid when `load_valid`
- `load_valid`  out  1  one-cycle pulse, load done
- `access_err`  out  1  one-cycle pulse, access failed

## Operation
- An access is pending when `mem_bweb != 4'b1111` or `is_load` ∈ {001..101}. If both hold, the store wins and the load is ignored.
- FSM states: IDLE, REQ, RESP, DONE.
  - IDLE: with an access pending, go to REQ, or to DONE with the error flag if the access is misaligned.
  - REQ: hold `bus_req_valid=1` with stable address, write, strobe and data until `bus_req_ready`, then go to RESP.
  - RESP: on `bus_rsp_valid`, capture `rdata` and `err`, then go to DONE.
  - DONE: one cycle, then IDLE.
- `stall` = 1 in IDLE with an access pending, in REQ and in RESP; 0 in DONE and in IDLE with no access. `stall` is forced to 0 while `rst` is high.
- Misalignment applies to loads only: LW with `addr[1:0]!=0`, or LH/LHU with `addr[1:0]==3`. No bus transaction is issued; DONE shows `access_err=1`, `load_valid=0`, `load_data=0`. Stores are never checked, because `mem_bweb` already encodes the lanes.
- Load extraction uses `addr[1:0]` to select the byte lane, or the halfword lane at `addr[1]`. LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
- On a bus error, DONE pulses `access_err=1`; for a load, `load_valid=0` and `load_data=0`.
- A store completes in DONE with `load_valid=0`.

## Timing
- Reset values: state IDLE; `bus_req_valid=0`; `load_valid=0`; `access_err=0`; `load_data=0`; the captured response registers are 0.
- Minimum latency with `ready` and `rsp` each high on their first eligible cycle:
  - cycle 0: IDLE detects the access, `stall=1`
  - cycle 1: REQ, handshake
  - cycle 2: RESP, response captured
  - cycle 3: DONE, `stall=0`, results visible
  - Stall length is 3 cycles.
- `load_data`, `load_valid` and `access_err` are registered and asserted only in DONE. The pipeline advances at the end of DONE, so the next access is seen in IDLE the following cycle and is never reissued.
- Boundary rules:
  - `bus_rsp_valid` outside RESP is ignored; this includes responses arriving in IDLE after a reset.
  - `ready` and `rsp_valid` in the same cycle as REQ: the response is not captured that cycle; the responder must respond at least one cycle after accept.
- Reset mid-operation: the next edge returns to IDLE with `bus_req_valid=0`, and the outstanding transaction is abandoned.

## Structure
- `dmem_pkg`: load-type enum (`LD_NONE`, `LD_W`, `LD_H`, `LD_B`, `LD_HU`, `LD_BU`), FSM state enum, constant `BWEB_NONE = 4'b1111`.
- Sub-module `load_align`: purely combinational extraction and extension (`rdata`, `addr[1:0]`, `is_load` -> 32-bit result). It is shared with any future cache path.

## Test plan
- LB at `0x1003`, `rdata=0x80FF_1234`, ready and response immediate: `load_data=0xFFFF_FF80` in cycle 3, `stall` high for cycles 0-2.
- LHU at `0x2002`, `rdata=0xBEEF_0000`, ready delayed 4 cycles: `bus_req_addr=0x2000` held stable throughout, `load_data=0x0000_BEEF`.
- SB, `bweb=4'b1101`, `wdata=0x0000_AB00`: `wstrb=4'b0010`, `write=1`; DONE has `load_valid=0`, `access_err=0`.
- LW at `0x3001`: no `bus_req_valid` ever; DONE in cycle 1 with `access_err=1`, `load_data=0`.
- LW with `bus_rsp_err=1`: `access_err` pulses one cycle, `load_valid=0`. Separately, `rst` asserted during RESP: IDLE next cycle, a late `rsp_valid` is ignored, and all outputs are 0.
- Back-to-back LW then SW: two distinct transactions with no duplicate request, and `stall` low for exactly one cycle between them.
